// File: rtl/video_pkg.sv
// video_pkg: shared constants and types for the video receive/measure path
package video_pkg;
    localparam int HVD_HS = 2;
    localparam int HVD_VS = 1;
    localparam int HVD_DE = 0;
    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
    localparam int VID_CNT_W = 12;
    typedef enum logic [1:0] {S_WAIT_VS, S_MEASURE, S_LOCKED} meas_state_t;
endpackage

// File: rtl/video_crc32_24.sv
// video_crc32_24: next CRC-32 (non-reflected) after shifting in a 24-bit word MSB first
module video_crc32_24
    import video_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [23:0] data_i,
    output logic [31:0] crc_o
);
    // unrolled bit-serial LFSR, data bit 23 enters first
    always_comb begin
        crc_o = crc_i;
        for (int i = 23; i >= 0; i--)
            crc_o = {crc_o[30:0], 1'b0} ^ ((crc_o[31] ^ data_i[i]) ? CRC32_POLY : 32'h0);
    end
endmodule

// File: rtl/video_timing_meas.sv
// video_timing_meas: measures H/V totals and active sizes, per-frame CRC-32 and timing lock
module video_timing_meas
    import video_pkg::*;
#(
    parameter int   CNT_W       = VID_CNT_W,
    parameter int   LOCK_FRAMES = 3,
    parameter logic HS_POL      = 1'b1,
    parameter logic VS_POL      = 1'b1
) (
    input  logic             CLK_i,
    input  logic             RST_i,
    input  logic [7:0]       VID_R_i,
    input  logic [7:0]       VID_G_i,
    input  logic [7:0]       VID_B_i,
    input  logic [2:0]       VID_HVD_i,
    output logic [CNT_W-1:0] H_TOTAL_o,
    output logic [CNT_W-1:0] H_ACTIVE_o,
    output logic [CNT_W-1:0] V_TOTAL_o,
    output logic [CNT_W-1:0] V_ACTIVE_o,
    output logic [31:0]      FRAME_CRC_o,
    output logic             UPDATE_o,
    output logic             LOCKED_o,
    output logic             ERROR_o
);
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    meas_state_t      state_q, state_d;
    logic [23:0]      pix_q, pix_d;
    logic [2:0]       hvd_q, hvd_d;
    logic             hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d, de_prev_q, de_prev_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, de_cnt_q, de_cnt_d;
    logic [CNT_W-1:0] h_tot_q, h_tot_d, h_act_q, h_act_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d, va_cnt_q, va_cnt_d;
    logic [CNT_W-1:0] ref_w_q, ref_w_d, ref_t_q, ref_t_d;
    logic             ref_w_vld_q, ref_w_vld_d, ref_t_vld_q, ref_t_vld_d;
    logic             line_de_q, line_de_d, trunc_q, trunc_d, bad_q, bad_d;
    logic [31:0]      crc_q, crc_d, crc_nxt, crc_upd;
    logic [3:0]       stable_q, stable_d;
    logic [CNT_W-1:0] h_total_q, h_total_d, h_active_q, h_active_d;
    logic [CNT_W-1:0] v_total_q, v_total_d, v_active_q, v_active_d;
    logic [31:0]      frame_crc_q, frame_crc_d;
    logic             update_q, update_d, error_q, error_d;
    logic             hs, vs, de, hs_rise, vs_rise, de_rise, de_fall, de_ok, line_de_now;
    logic             bad_now, frame_ev, same;
    logic [CNT_W-1:0] v_end, va_end;

    video_crc32_24 u_crc (.crc_i(crc_q), .data_i(pix_q), .crc_o(crc_nxt));

    // edge detection, line/frame counters, consistency checks and CRC accumulation
    always_comb begin
        pix_d = {VID_R_i, VID_G_i, VID_B_i};
        hvd_d = VID_HVD_i;
        hs = hvd_q[HVD_HS] == HS_POL;
        vs = hvd_q[HVD_VS] == VS_POL;
        de = hvd_q[HVD_DE];
        hs_prev_d = hs;
        vs_prev_d = vs;
        de_prev_d = de;
        hs_rise = hs & ~hs_prev_q;
        vs_rise = vs & ~vs_prev_q;
        de_rise = de & ~de_prev_q;
        de_fall = ~de & de_prev_q;
        de_ok = de_fall & ~trunc_q;
        h_cnt_d = hs_rise ? ONE : (h_cnt_q == MAX) ? MAX : h_cnt_q + ONE;
        h_tot_d = hs_rise ? h_cnt_q : h_tot_q;
        de_cnt_d = de_rise ? ONE : (de && de_cnt_q != MAX) ? de_cnt_q + ONE : de_cnt_q;
        h_act_d = de_ok ? de_cnt_q : h_act_q;
        v_end = (hs_rise && v_cnt_q != MAX) ? v_cnt_q + ONE : v_cnt_q;
        va_end = (de_ok && va_cnt_q != MAX) ? va_cnt_q + ONE : va_cnt_q;
        line_de_now = line_de_q | de_ok;
        bad_now = bad_q | (h_cnt_q == MAX) | (de_cnt_q == MAX) | (v_cnt_q == MAX) | (va_cnt_q == MAX)
                | (de_ok & ref_w_vld_q & (de_cnt_q != ref_w_q))
                | (hs_rise & line_de_now & ref_t_vld_q & (h_cnt_q != ref_t_q));
        ref_w_d = (de_ok && !ref_w_vld_q) ? de_cnt_q : ref_w_q;
        ref_t_d = (hs_rise && line_de_now && !ref_t_vld_q) ? h_cnt_q : ref_t_q;
        ref_w_vld_d = ~vs_rise & (ref_w_vld_q | de_ok);
        ref_t_vld_d = ~vs_rise & (ref_t_vld_q | (hs_rise & line_de_now));
        line_de_d = ~vs_rise & ~hs_rise & line_de_now;
        trunc_d = vs_rise ? de : de_fall ? 1'b0 : trunc_q;
        crc_upd = (de && !trunc_q) ? crc_nxt : crc_q;
        crc_d = vs_rise ? CRC32_INIT : crc_upd;
        v_cnt_d = vs_rise ? '0 : v_end;
        va_cnt_d = vs_rise ? '0 : va_end;
        bad_d = ~vs_rise & bad_now;
    end

    // frame boundary: latch results, track stability and choose the next state
    always_comb begin
        frame_ev = vs_rise && state_q != S_WAIT_VS;
        same = h_tot_d == h_total_q && h_act_d == h_active_q && v_end == v_total_q && va_end == v_active_q;
        state_d = state_q;
        stable_d = stable_q;
        h_total_d = frame_ev ? h_tot_d : h_total_q;
        h_active_d = frame_ev ? h_act_d : h_active_q;
        v_total_d = frame_ev ? v_end : v_total_q;
        v_active_d = frame_ev ? va_end : v_active_q;
        frame_crc_d = frame_ev ? crc_upd : frame_crc_q;
        update_d = frame_ev;
        error_d = frame_ev & bad_now;
        if (frame_ev)
            stable_d = (same && !bad_now) ? ((stable_q == 4'hF) ? stable_q : stable_q + 4'd1) : 4'd0;
        if (vs_rise)
            state_d = (stable_d >= 4'(LOCK_FRAMES)) ? S_LOCKED : S_MEASURE;
    end

    // FSM state register
    always_ff @(posedge CLK_i) begin
        if (RST_i) state_q <= S_WAIT_VS;
        else state_q <= state_d;
    end

    // datapath and output registers; sync history resets asserted so no false edge follows reset
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            pix_q <= '0;
            hvd_q <= '0;
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
            de_prev_q <= 1'b0;
            h_cnt_q <= '0;
            de_cnt_q <= '0;
            h_tot_q <= '0;
            h_act_q <= '0;
            v_cnt_q <= '0;
            va_cnt_q <= '0;
            ref_w_q <= '0;
            ref_t_q <= '0;
            ref_w_vld_q <= 1'b0;
            ref_t_vld_q <= 1'b0;
            line_de_q <= 1'b0;
            trunc_q <= 1'b0;
            bad_q <= 1'b0;
            crc_q <= CRC32_INIT;
            stable_q <= '0;
            h_total_q <= '0;
            h_active_q <= '0;
            v_total_q <= '0;
            v_active_q <= '0;
            frame_crc_q <= '0;
            update_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            pix_q <= pix_d;
            hvd_q <= hvd_d;
            hs_prev_q <= hs_prev_d;
            vs_prev_q <= vs_prev_d;
            de_prev_q <= de_prev_d;
            h_cnt_q <= h_cnt_d;
            de_cnt_q <= de_cnt_d;
            h_tot_q <= h_tot_d;
            h_act_q <= h_act_d;
            v_cnt_q <= v_cnt_d;
            va_cnt_q <= va_cnt_d;
            ref_w_q <= ref_w_d;
            ref_t_q <= ref_t_d;
            ref_w_vld_q <= ref_w_vld_d;
            ref_t_vld_q <= ref_t_vld_d;
            line_de_q <= line_de_d;
            trunc_q <= trunc_d;
            bad_q <= bad_d;
            crc_q <= crc_d;
            stable_q <= stable_d;
            h_total_q <= h_total_d;
            h_active_q <= h_active_d;
            v_total_q <= v_total_d;
            v_active_q <= v_active_d;
            frame_crc_q <= frame_crc_d;
            update_q <= update_d;
            error_q <= error_d;
        end
    end

    assign H_TOTAL_o = h_total_q;
    assign H_ACTIVE_o = h_active_q;
    assign V_TOTAL_o = v_total_q;
    assign V_ACTIVE_o = v_active_q;
    assign FRAME_CRC_o = frame_crc_q;
    assign UPDATE_o = update_q;
    assign ERROR_o = error_q;
    assign LOCKED_o = state_q == S_LOCKED;
endmodule

// File: tb/tb_video_timing_meas.sv
// tb_video_timing_meas: scoreboard bench driving both sync polarities with the same frames
module tb_video_timing_meas;
    typedef struct packed {
        logic [11:0] ht, ha, vt, va;
        logic [31:0] crc;
        logic        err, lk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  hvd = '0;
    logic [23:0] pix = '0;
    logic [11:0] ht[2], ha[2], vt[2], va[2];
    logic [31:0] crc[2];
    logic        upd[2], lk[2], err[2];

    exp_t        sb[$];
    int          rd[2] = '{0, 0};
    int          errors = 0, checks = 0, drain = 0;
    bit          rst_was = 0, done_req = 0, fin = 0;
    exp_t        mon_e;

    exp_t        pend;
    bit          has_prev = 0;
    logic [47:0] prev_meas = '0;
    int          stable = 0;

    always #5 clk = ~clk;

    video_timing_meas dut_a (
        .CLK_i(clk), .RST_i(rst), .VID_R_i(pix[23:16]), .VID_G_i(pix[15:8]), .VID_B_i(pix[7:0]),
        .VID_HVD_i(hvd), .H_TOTAL_o(ht[0]), .H_ACTIVE_o(ha[0]), .V_TOTAL_o(vt[0]), .V_ACTIVE_o(va[0]),
        .FRAME_CRC_o(crc[0]), .UPDATE_o(upd[0]), .LOCKED_o(lk[0]), .ERROR_o(err[0]));

    video_timing_meas #(.HS_POL(1'b0), .VS_POL(1'b0)) dut_b (
        .CLK_i(clk), .RST_i(rst), .VID_R_i(pix[23:16]), .VID_G_i(pix[15:8]), .VID_B_i(pix[7:0]),
        .VID_HVD_i({~hvd[2], ~hvd[1], hvd[0]}), .H_TOTAL_o(ht[1]), .H_ACTIVE_o(ha[1]), .V_TOTAL_o(vt[1]),
        .V_ACTIVE_o(va[1]), .FRAME_CRC_o(crc[1]), .UPDATE_o(upd[1]), .LOCKED_o(lk[1]), .ERROR_o(err[1]));

    function automatic logic [31:0] crc_ref(input logic [23:0] px, input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        logic [7:0]  by;
        for (int k = 0; k < n * 3; k++) begin
            by = 8'(px >> (8 * (2 - k % 3)));
            for (int j = 7; j >= 0; j--)
                c = (c[31] ^ by[j]) ? ({c[30:0], 1'b0} ^ 32'h04C11DB7) : {c[30:0], 1'b0};
        end
        return c;
    endfunction

    task automatic cmp(input string nm, input int d, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, want, $time);
        end
    endtask

    task automatic drive(input logic hs, input logic vs, input logic de, input logic [23:0] px);
        hvd = {hs, vs, de};
        pix = px;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [23:0] px, input bit shrt, input bit gap, input bit rm);
        exp_t e;
        bit   same;
        logic de;
        if (has_prev) sb.push_back(pend);
        e.ht = gap ? 12'd4095 : 12'd32;
        e.ha = 12'd20;
        e.vt = 12'd16;
        e.va = 12'd10;
        e.crc = crc_ref(px, shrt ? 199 : 200);
        e.err = shrt | gap;
        same = {e.ht, e.ha, e.vt, e.va} == prev_meas;
        stable = (same && !e.err) ? (stable < 15 ? stable + 1 : 15) : 0;
        e.lk = stable >= 3;
        prev_meas = {e.ht, e.ha, e.vt, e.va};
        pend = e;
        has_prev = 1;
        for (int l = 0; l < 16; l++)
            for (int p = 0; p < 32; p++) begin
                de = l >= 3 && l <= 12 && p >= 8 && p < ((shrt && l == 5) ? 27 : 28);
                rst = rm && l == 6 && p == 0;
                drive(p < 4, l < 2, de, de ? px : 24'h0);
            end
        if (rm) begin
            has_prev = 0;
            prev_meas = '0;
            stable = 0;
        end
        if (gap) repeat (5000) drive(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    always @(negedge clk) begin
        if (rst_was)
            for (int d = 0; d < 2; d++) begin
                cmp("rst_meas", d, {16'h0, ht[d], ha[d], vt[d], va[d]}, 64'h0);
                cmp("rst_crc", d, 64'(crc[d]), 64'h0);
                cmp("rst_flags", d, {61'h0, upd[d], lk[d], err[d]}, 64'h0);
            end
        rst_was = rst;
        for (int d = 0; d < 2; d++) begin
            if (upd[d]) begin
                if (rd[d] >= sb.size()) cmp("unexpected_update", d, 64'(upd[d]), 64'h0);
                else begin
                    mon_e = sb[rd[d]];
                    rd[d]++;
                    cmp("h_total", d, 64'(ht[d]), 64'(mon_e.ht));
                    cmp("h_active", d, 64'(ha[d]), 64'(mon_e.ha));
                    cmp("v_total", d, 64'(vt[d]), 64'(mon_e.vt));
                    cmp("v_active", d, 64'(va[d]), 64'(mon_e.va));
                    cmp("frame_crc", d, 64'(crc[d]), 64'(mon_e.crc));
                    cmp("error", d, 64'(err[d]), 64'(mon_e.err));
                    cmp("locked", d, 64'(lk[d]), 64'(mon_e.lk));
                end
            end else if (err[d]) cmp("error_without_update", d, 64'(err[d]), 64'h0);
        end
        if (done_req && !fin) begin
            if (rd[0] == sb.size() && rd[1] == sb.size()) fin = 1;
            else if (++drain > 200) begin
                for (int d = 0; d < 2; d++) cmp("updates_missing", d, 64'(sb.size() - rd[d]), 64'h0);
                fin = 1;
            end
        end
    end

    initial begin
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 1'b0, 24'h0);
        for (int f = 0; f < 23; f++)
            send_frame((f == 5 || f == 6) ? 24'hFF0000 : (f == 7) ? 24'h123456 : 24'h000000,
                       f == 7, f == 12, f == 18);
        repeat (10) drive(1'b0, 1'b0, 1'b0, 24'h0);
        done_req = 1;
        wait (fin);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/video_timing_meas.md
Name: video_timing_meas

Overview:
- Receive-side counterpart of the video generator/starfield chain. Consumes a pixel-rate RGB + H/V/DE stream and measures the frame timing: horizontal and vertical totals and active sizes.
- Computes a per-frame CRC-32 over the active pixels and reports lock once timing has been stable for several frames.
- Used as a loopback checker on the video output path, and as the front end of future capture logic.

Parameters:
- CNT_W, 12, width of every timing counter and measurement output.
- LOCK_FRAMES, 3, consecutive identical frames required before LOCKED_o asserts (1..15).
- HS_POL, 1, active level of HVD[2] (hsync).
- VS_POL, 1, active level of HVD[1] (vsync).

Ports:
- CLK_i  in  1  pixel clock.
- RST_i  in  1  synchronous reset, active-high.
- VID_R_i  in  8  red.
- VID_G_i  in  8  green.
- VID_B_i  in  8  blue.
- VID_HVD_i  in  3  [2]=hsync, [1]=vsync, [0]=data enable (DE active-high).
- H_TOTAL_o  out  CNT_W  clocks per line.
- H_ACTIVE_o  out  CNT_W  DE-high clocks per line.
- V_TOTAL_o  out  CNT_W  lines per frame.
- V_ACTIVE_o  out  CNT_W  lines containing DE per frame.
- FRAME_CRC_o  out  32  CRC-32 of active pixels in the last complete frame.
- UPDATE_o  out  1  one-cycle pulse when the measurement outputs are refreshed.
- LOCKED_o  out  1  timing stable.
- ERROR_o  out  1  one-cycle pulse on an inconsistent or saturated frame.

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high; every output is reset to 0 and the FSM goes to S_WAIT_VS.
- Input register: all inputs are registered once. Edges are detected on the registered copy, with sync levels normalized by HS_POL/VS_POL.
- Horizontal counting:
  - h_cnt increments every clock and reloads to 1 on hsync assertion.
  - The value just before the reload is latched as the line total.
  - de_cnt counts DE-high clocks and is latched at the DE falling edge as the line active width.
- Vertical counting:
  - v_cnt counts hsync assertions since the last vsync assertion.
  - va_cnt counts DE falling edges since the last vsync assertion.
- Line consistency: the first DE line of a frame sets the reference line width and line total. Any later line in the same frame that differs sets frame_bad.
- Saturation: a counter reaching 2^CNT_W-1 holds there and sets frame_bad.
- CRC:
  - CRC-32, polynomial 0x04C11DB7, non-reflected, no final XOR.
  - Init value 0xFFFFFFFF at vsync assertion.
  - On each DE cycle the 24-bit word {R,G,B} (R in the MSBs) is shifted in MSB first.
- FSM:
  - S_WAIT_VS: ignore everything until the first vsync assertion, then clear the counters, init the CRC and go to S_MEASURE. No UPDATE_o on this edge.
  - S_MEASURE / S_LOCKED: on each vsync assertion:
    - Latch the frame results to the outputs and pulse UPDATE_o.
    - Compare against the previous frame's four values. If they are equal and the frame is not bad, increment stable_cnt (saturating); otherwise clear stable_cnt to 0.
    - ERROR_o pulses when frame_bad is set.
    - Restart the counters and the CRC.
  - LOCKED_o = 1 when stable_cnt ≥ LOCK_FRAMES (state S_LOCKED). It drops the cycle after any mismatching or bad frame.
- Latency: a vsync assertion at the input in cycle N gives UPDATE_o, the new outputs and LOCKED_o/ERROR_o in cycle N+2.
- Simultaneous hsync and vsync assertion: the hsync terminates the last line of the old frame (counted in the old v_cnt), and the new frame begins with v_cnt=0.
- A DE falling edge coincident with vsync counts toward the old frame.
- A DE still high at vsync is truncated: its pixels belong to the old CRC, and the line is not counted in va_cnt.
- Outputs hold their values between updates.

Decomposition:
- Shared package video_pkg:
  - HVD bit indices (HVD_HS=2, HVD_VS=1, HVD_DE=0).
  - CRC32_POLY, CRC32_INIT.
  - Default CNT_W.
- Sub-module video_crc32_24: combinational next-CRC from (crc[31:0], data[23:0]). It is reusable by a future transmit-side CRC inserter.

Test Plan:
- Generator with H_TOTAL=32, H_ACTIVE=20, V_TOTAL=16, V_ACTIVE=10, syncs active-high, LOCK_FRAMES=3 → after the 2nd vsync, H_TOTAL_o=32, H_ACTIVE_o=20, V_TOTAL_o=16, V_ACTIVE_o=10, UPDATE_o pulses once per frame; LOCKED_o=1 after the 4th update.
- Constant pixel 0x000000 for all 200 active pixels → FRAME_CRC_o equals the reference-model CRC-32 of 600 zero bytes (MSB first, init 0xFFFFFFFF, no final XOR). Pixel 0xFF0000 gives a different, model-matched value.
- Locked stream, then one frame with a line of DE width 19 → that frame's update asserts ERROR_o, LOCKED_o falls at N+2, and relock occurs after 3 further good frames.
- Hsync held inactive for 5000 clocks → H_TOTAL_o=4095 at the next update, ERROR_o=1, LOCKED_o=0.
- RST_i asserted mid-frame while locked → all outputs 0 the next cycle; the first post-reset vsync gives no UPDATE_o, the second does.
- HS_POL=0, VS_POL=0 with inverted syncs → same measurements as the first scenario.
